// File: rtl/mux_arb_nto1.sv
// mux_arb_nto1: N-to-1 registered mux with per-channel valid/ready and built-in arbitration.
// Define MUX_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module mux_arb_nto1 #(
    parameter int unsigned  WIDTH = 4,
    parameter int unsigned  NCH   = 4,
    localparam int unsigned SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic             can_load;
    logic             req_any;
    logic             load;
    logic [SELW-1:0]  grant;
    logic [WIDTH-1:0] grant_data;

`ifdef MUX_ARB_RR_EN
    logic [SELW-1:0] rr_ptr_q, rr_ptr_d;
    logic [SELW:0]   idx;

    // Rotating search starting at rr_ptr, wrapping NCH-1 -> 0
    always_comb begin
        grant   = '0;
        req_any = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            idx = {1'b0, rr_ptr_q} + (SELW+1)'(i);
            if (idx >= (SELW+1)'(NCH)) begin
                idx = idx - (SELW+1)'(NCH);
            end
            if (!req_any && in_valid[idx[SELW-1:0]]) begin
                grant   = idx[SELW-1:0];
                req_any = 1'b1;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (load) begin
            rr_ptr_d = (grant == SELW'(NCH - 1)) ? '0 : grant + SELW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    // Fixed priority: lowest requesting index wins
    always_comb begin
        grant   = '0;
        req_any = 1'b0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (!req_any && in_valid[k]) begin
                grant   = SELW'(k);
                req_any = 1'b1;
            end
        end
    end
`endif

    // Data select uses constant part-selects so in_data only reaches flop inputs
    always_comb begin
        grant_data = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (grant == SELW'(k)) begin
                grant_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign can_load = !out_valid_q || out_ready;
    assign load     = can_load && req_any;

    always_comb begin
        in_ready = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            in_ready[k] = rst_n && load && (grant == SELW'(k));
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data;
            out_ch_d    = grant;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: doc/mux_arb_nto1.md
# mux_arb_nto1

Parametrised N-channel, W-bit registered multiplexer with per-channel valid/ready handshakes and built-in arbitration. It generalises the 2:1 select path: instead of an external `sel`, the block picks one requesting input channel per cycle, registers its data together with the winning channel index, and presents it on a single valid/ready output port. It sits between several producer blocks and one shared consumer (bus, FIFO, or datapath stage).

## Interface
- `WIDTH`, 4, data width per channel in bits (1..32)
- `NCH`, 4, number of input channels (2..16)
- `SELW`, localparam = ceil(log2(NCH)), width of the channel index

- `clk`  input  1  rising-edge clock
- `rst_n`  input  1  reset; asynchronous and active-low
- `in_data`  input  NCH*WIDTH  packed channel data; channel k at bits [k*WIDTH +: WIDTH]
- `in_valid`  input  NCH  channel k has data
- `in_ready`  output  NCH  channel k transfer accepted this cycle (one-hot or zero)
- `out_data`  output  WIDTH  registered data of the winning channel
- `out_ch`  output  SELW  registered index of the channel that supplied `out_data`
- `out_valid`  output  1  output register holds data
- `out_ready`  input  1  consumer accepts `out_data` this cycle

## Operation
- One-entry output register (`out_data`, `out_ch`, `out_valid`) plus arbitration pointer `rr_ptr` (SELW bits).
- `can_load` = !out_valid | out_ready (register empty, or draining this cycle).
- Grant `g`: selected among channels with `in_valid` set, per arbitration mode (see Configuration). No request -> no grant.
- `in_ready[g]` = `can_load` & `in_valid[g]`; all other `in_ready` bits 0. `in_ready` is combinational from `in_valid`, `out_valid`, `out_ready`, `rr_ptr`.
- Transfer on channel k when `in_valid[k]` & `in_ready[k]`. At that edge: `out_data` <= channel k data, `out_ch` <= k, `out_valid` <= 1.
- Output transfer when `out_valid` & `out_ready`. If no input transfer in the same cycle, `out_valid` <= 0; `out_data`/`out_ch` hold their last values.
- Simultaneous output drain and input load: register reloads; `out_valid` stays 1 (no bubble).
- While `out_valid` & !`out_ready`: `out_data`, `out_ch` stable; all `in_ready` = 0.
- Channel index k >= NCH never granted; unused `out_ch` codes never produced.

## Timing
- Reset (async assert, sync release on next `clk` edge): `out_valid`=0, `out_data`=0, `out_ch`=0, `rr_ptr`=0; `in_ready` = 0 while `rst_n` low.
- Reset mid-transfer: pending output data discarded, no transfer counted on either side.
- Latency: input transfer at edge t -> `out_valid`=1 from edge t, visible cycle t+1.
- Throughput: 1 transfer/cycle sustained with `out_ready` held 1.
- No combinational path from `in_data` to outputs.

## Configuration
- Macro `MUX_ARB_RR_EN`.
- Defined: round-robin. Search starts at `rr_ptr`, ascends with wrap from NCH-1 to 0; first valid channel wins. On each input transfer from channel g, `rr_ptr` <= (g == NCH-1) ? 0 : g+1. No transfer -> `rr_ptr` holds. Any continuously valid channel granted within NCH transfers.
- Undefined: fixed priority, lowest index wins; `rr_ptr` not implemented (no register), starvation of high indices permitted.

## Test plan
- Reset: drive `rst_n`=0 mid-cycle with `in_valid`=4'b1111 -> `out_valid`=0, `out_data`=0, `out_ch`=0, `in_ready`=0 immediately, without clock edge.
- Single channel: WIDTH=4, NCH=4, `in_valid`=4'b0100, data ch2=4'hA, `out_ready`=1 -> `in_ready`=4'b0100; next cycle `out_data`=4'hA, `out_ch`=2, `out_valid`=1.
- Backpressure: load ch1=4'h5, hold `out_ready`=0 for 3 cycles with `in_valid`=4'b1111 -> `in_ready`=0, `out_data`=4'h5, `out_ch`=1 stable; raise `out_ready` -> next channel loaded same edge, `out_valid` never drops.
- Round-robin (`MUX_ARB_RR_EN`): all four valid, `out_ready`=1 continuously for 8 cycles -> `out_ch` sequence 0,1,2,3,0,1,2,3.
- Fixed priority (macro undefined): same stimulus -> `out_ch`=0 every cycle, `in_ready`=4'b0001 throughout.
- Wrap/idle: RR, grant ch3 (`rr_ptr`->0), then idle 2 cycles, then `in_valid`=4'b1010 -> ch1 granted; drain with no new request -> `out_valid`=0 next cycle.
